// File: rtl/bram_bus_pkg.sv
// Shared types and helpers for the BRAM bus master and its lane aligner.
package bram_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ACC1,
      ACC2,
      WAIT,
      RESP
   } state_t;

   localparam logic SZ_BYTE = 1'b0;
   localparam logic SZ_WORD = 1'b1;

   // Byte-enable mask for the first access of a request; a word starting at
   // lane 3 naturally truncates to 4'b1000, which is the low half of a split.
   function automatic logic [3:0] lane_mask(input logic size, input logic [1:0] offset);
      logic [3:0] base;
      base = (size == SZ_WORD) ? 4'b0011 : 4'b0001;
      return base << offset;
   endfunction

endpackage

// File: rtl/bram_bus_master_if.sv
// CPU request/response handshake plus the 32-bit BRAM port, bundled together.
interface bram_bus_master_if #(
   parameter int ADDR_W = 15
);

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic              req_size;
   logic [ADDR_W-1:0] req_addr;
   logic [15:0]       req_wdata;
   logic              rsp_valid;
   logic [15:0]       rsp_rdata;
   logic [ADDR_W-3:0] mem_addr;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport master (
      input  req_valid, req_we, req_size, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_we, mem_be, mem_wdata
   );

   modport slave (
      output req_valid, req_we, req_size, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_we, mem_be, mem_wdata
   );

endinterface

// File: rtl/bram_lane_align.sv
// Places 16-bit write data onto 32-bit lanes and picks read bytes back out.
// The high byte always sits one lane above the low byte, wrapping lane 3 to
// lane 0, so one packed word serves both halves of a split access.
module bram_lane_align
   import bram_bus_pkg::*;
(
   input  logic        size,
   input  logic [1:0]  offset,
   input  logic [15:0] wdata,
   input  logic [31:0] rdata,
   output logic [31:0] wdata_lanes,
   output logic [7:0]  rd_lo,
   output logic [7:0]  rd_hi
);

   logic [1:0] hi_lane;

   // Lane packing for writes and lane extraction for reads.
   always_comb begin
      hi_lane     = offset + 2'd1;
      wdata_lanes = '0;
      wdata_lanes[{offset, 3'b000} +: 8] = wdata[7:0];
      if (size == SZ_WORD) begin
         wdata_lanes[{hi_lane, 3'b000} +: 8] = wdata[15:8];
      end
      rd_lo = rdata[{offset, 3'b000} +: 8];
      rd_hi = rdata[{hi_lane, 3'b000} +: 8];
   end

endmodule

// File: rtl/bram_bus_master.sv
// Turns single 8/16-bit CPU requests into one or two byte-enabled 32-bit BRAM
// accesses, absorbing the BRAM's one-cycle read latency. Every output is a
// register loaded from the value it should hold in the next state.
module bram_bus_master
   import bram_bus_pkg::*;
#(
   parameter int ADDR_W  = 15,
   parameter bit WRAP_EN = 1'b1
) (
   input logic clock,
   input logic reset,
   bram_bus_master_if.master bus
);

   localparam int WORD_W = ADDR_W - 2;

   state_t            state;
   state_t            next_state;

   logic              we_q;
   logic              size_q;
   logic [1:0]        off_q;
   logic [WORD_W-1:0] word_q;
   logic [7:0]        lo_q;

   logic              accept;
   logic              split;
   logic              top_word;
   logic              do_acc2;
   logic              align_size;
   logic [1:0]        align_off;
   logic [31:0]       wdata_lanes;
   logic [7:0]        rd_lo;
   logic [7:0]        rd_hi;

   logic              ready_n;
   logic              rsp_valid_n;
   logic [15:0]       rsp_rdata_n;
   logic [WORD_W-1:0] mem_addr_n;
   logic              mem_we_n;
   logic [3:0]        mem_be_n;
   logic [31:0]       mem_wdata_n;

   // While idle the aligner looks at the incoming request; afterwards it
   // works from the latched request so it can extract read bytes.
   always_comb begin
      accept     = bus.req_valid && bus.req_ready;
      split      = (size_q == SZ_WORD) && (off_q == 2'd3);
      top_word   = &word_q;
      do_acc2    = split && (WRAP_EN || !top_word);
      align_size = (state == IDLE) ? bus.req_size : size_q;
      align_off  = (state == IDLE) ? bus.req_addr[1:0] : off_q;
   end

   bram_lane_align u_align (
      .size        (align_size),
      .offset      (align_off),
      .wdata       (bus.req_wdata),
      .rdata       (bus.mem_rdata),
      .wdata_lanes (wdata_lanes),
      .rd_lo       (rd_lo),
      .rd_hi       (rd_hi)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; writes need no read-capture cycle so they skip WAIT.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (accept) next_state = ACC1;
         ACC1: begin
            if (do_acc2)   next_state = ACC2;
            else if (we_q) next_state = RESP;
            else           next_state = WAIT;
         end
         ACC2:    next_state = we_q ? RESP : WAIT;
         WAIT:    next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Next values of the registered outputs, keyed on the state being entered.
   // When entering RESP from WAIT, mem_rdata holds the last word accessed.
   always_comb begin
      ready_n     = (next_state == IDLE);
      rsp_valid_n = (next_state == RESP);
      rsp_rdata_n = bus.rsp_rdata;
      if (next_state == RESP) begin
         if (we_q)                         rsp_rdata_n = '0;
         else if (split && do_acc2)        rsp_rdata_n = {rd_hi, lo_q};
         else if (split)                   rsp_rdata_n = {8'h00, rd_lo};
         else if (size_q == SZ_WORD)       rsp_rdata_n = {rd_hi, rd_lo};
         else                              rsp_rdata_n = {8'h00, rd_lo};
      end

      mem_addr_n = bus.mem_addr;
      if (state == IDLE && accept) begin
         mem_addr_n = bus.req_addr[ADDR_W-1:2];
      end else if (next_state == ACC2) begin
         mem_addr_n = word_q + 1'b1;
      end

      mem_we_n    = 1'b0;
      mem_be_n    = 4'b0000;
      mem_wdata_n = bus.mem_wdata;
      if (next_state == ACC1) begin
         mem_we_n    = bus.req_we;
         mem_be_n    = lane_mask(bus.req_size, bus.req_addr[1:0]);
         mem_wdata_n = wdata_lanes;
      end else if (next_state == ACC2) begin
         mem_we_n = we_q;
         mem_be_n = 4'b0001;
      end
   end

   // Output registers, request context, and the split-read low-byte capture.
   always_ff @(posedge clock) begin
      if (reset) begin
         bus.req_ready <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.mem_addr  <= '0;
         bus.mem_we    <= 1'b0;
         bus.mem_be    <= '0;
         bus.mem_wdata <= '0;
         we_q          <= 1'b0;
         size_q        <= SZ_BYTE;
         off_q         <= '0;
         word_q        <= '0;
         lo_q          <= '0;
      end else begin
         bus.req_ready <= ready_n;
         bus.rsp_valid <= rsp_valid_n;
         bus.rsp_rdata <= rsp_rdata_n;
         bus.mem_addr  <= mem_addr_n;
         bus.mem_we    <= mem_we_n;
         bus.mem_be    <= mem_be_n;
         bus.mem_wdata <= mem_wdata_n;
         if (accept) begin
            we_q   <= bus.req_we;
            size_q <= bus.req_size;
            off_q  <= bus.req_addr[1:0];
            word_q <= bus.req_addr[ADDR_W-1:2];
         end
         if (state == ACC2) begin
            lo_q <= rd_lo;
         end
      end
   end

endmodule
